multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM of the multicycle MIPS datapath.
- Decodes the IR opcode and sequences fetch/decode/execute/memory/writeback.
- Owns the 7-bit control state and drives every datapath enable and mux select: PC, IR, MDR, A/B, ALUOut loads, register file and memory strobes.
- Stalls on memory states until the memory handshake completes.

Parameters:
- STATE_W, 7, width of state encoding and of `state` output.
- OPC_W, 6, opcode field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPC_W  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (branch).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write data select: 1 = MDR.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  STATE_W  current state, for debug/trace.
- illegal_op  out  1  sticky unknown-opcode flag.
- instr_count  out  32  count of retired instructions.

Behaviour:
- Synchronous reset, sampled on the clk rising edge:
  - state <= FETCH, illegal_op <= 0, instr_count <= 0.
  - While reset is high, all strobes are forced 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write.
  - All selects read 0 during reset.
- Outputs are a combinational decode of the registered state (Moore). The only exception is mem_ready qualification, noted below. Unlisted outputs are 0.
- FETCH (0):
  - Drives mem_read=1, alu_src_b=01.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Next state: DECODE if mem_ready, else hold.
- DECODE (1): alu_src_b=11. Dispatch on opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> ADDIEX.
  - Any other opcode -> TRAP.
- MEMADR (2): alu_src_a=1, alu_src_b=10. Next: MEMRD if lw, MEMWR if sw.
- MEMRD (3): i_or_d=1, mem_read=1. Next: MEMWB on mem_ready, else hold.
- MEMWB (4): reg_write=1, mem_to_reg=1. Next: FETCH.
- MEMWR (5): i_or_d=1, mem_write=1. Next: FETCH on mem_ready, else hold.
- EXEC (6): alu_src_a=1, alu_op=10. Next: ALUWB.
- ALUWB (7): reg_write=1, reg_dst=1. Next: FETCH.
- BRANCH (8): alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1. Next: FETCH.
- JUMP (9): pc_write=1, pc_source=10. Next: FETCH.
- ADDIEX (10): alu_src_a=1, alu_src_b=10. Next: ADDIWB.
- ADDIWB (11): reg_write=1. Next: FETCH.
- TRAP (12):
  - All strobes 0. Sets illegal_op=1 on entry.
  - Holds until reset. The PC is not advanced.
- Any unused state encoding -> FETCH next cycle, all strobes 0.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. It wraps from 0xFFFFFFFF to 0.
- Latency in cycles, with mem_ready=1 every cycle:
  - lw 5.
  - sw, R-type, addi 4.
  - beq, j 3.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset takes priority over every transition, including mid-stall and mid-instruction. No partial write is issued in the reset cycle.
- mem_ready is ignored in states that do not access memory.

Decomposition:
- multicycle_pkg holds:
  - State encodings (FETCH…TRAP, STATE_W).
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI).
  - alu_op, alu_src_b and pc_source encodings.
- One combinational sub-module, control_output_decode, maps (state, mem_ready, reset) to all strobes and selects.
- The top level holds the next-state logic, the state register, illegal_op and instr_count.

Test Plan:
1. Reset, then lw (opcode 100011) with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count=1.
2. sw with mem_ready low for 3 cycles in MEMWR -> state holds at 5 with mem_write=1 for 4 cycles total; no reg_write; then FETCH, instr_count increments.
3. R-type, beq, j, addi back-to-back with mem_ready=1 -> cycle counts 4,3,3,4. Check pc_write_cond=1 only in state 8, pc_source=10 with pc_write=1 in state 9, and instr_count=4.
4. FETCH with mem_ready=0 for 2 cycles -> mem_read=1 throughout; ir_write and pc_write stay 0 until the mem_ready=1 cycle; then DECODE.
5. Opcode 111111 in DECODE -> TRAP (12); illegal_op=1 and held for 10+ cycles with all strobes 0. Assert reset -> state=0, illegal_op=0, instr_count=0.
6. Reset asserted during MEMRD stall -> next edge state=0; no reg_write or mem_write is issued in or after the reset cycle.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control path: state numbers, opcodes
// and the ALU/PC mux select codes.
package multicycle_pkg;

    localparam int unsigned MC_STATE_W = 7;
    localparam int unsigned MC_OPC_W   = 6;

    typedef enum logic [MC_STATE_W-1:0] {
        FETCH  = 7'd0,
        DECODE = 7'd1,
        MEMADR = 7'd2,
        MEMRD  = 7'd3,
        MEMWB  = 7'd4,
        MEMWR  = 7'd5,
        EXEC   = 7'd6,
        ALUWB  = 7'd7,
        BRANCH = 7'd8,
        JUMP   = 7'd9,
        ADDIEX = 7'd10,
        ADDIWB = 7'd11,
        TRAP   = 7'd12
    } state_e;

    localparam logic [MC_OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [MC_OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [MC_OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [MC_OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [MC_OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [MC_OPC_W-1:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_output_decode.sv
// Moore decode of the control state into datapath strobes and mux selects;
// mem_ready only qualifies the IR/PC loads in FETCH.
module control_output_decode
    import multicycle_pkg::*;
(
    input  logic [MC_STATE_W-1:0] state,
    input  logic                  mem_ready,
    input  logic                  reset,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [1:0]            pc_source
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        // Reset gates everything so no partial write leaks out mid-instruction.
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = ALUB_IMM_SH;
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                MEMRD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_source     = PCSRC_ALUOUT;
                    pc_write_cond = 1'b1;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                ADDIWB: begin
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction,
// tracks the sticky illegal-opcode flag and counts retired instructions.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned STATE_W = MC_STATE_W,
    parameter int unsigned OPC_W   = MC_OPC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state,
    output logic               illegal_op,
    output logic [31:0]        instr_count
);

    // Kept as plain logic so unused encodings are representable and recover.
    logic [MC_STATE_W-1:0] state_q, state_d;
    logic                  illegal_op_q;
    logic [31:0]           instr_count_q;
    logic                  retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH from a final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: retire = 1'b1;
            MEMWR:   retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            illegal_op_q  <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP) begin
                illegal_op_q <= 1'b1;
            end
            if (retire) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
        end
    end

    control_output_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source)
    );

    assign state       = STATE_W'(state_q);
    assign illegal_op  = illegal_op_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, corner
// sequences and a randomized run against an instruction-path reference model.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [6:0]  state;
    logic        illegal_op;
    logic [31:0] instr_count;
    logic [15:0] outs;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input logic [5:0] op, input bit mr);
        reset     = r;
        opcode    = op;
        mem_ready = mr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control word each state must present, written straight from the state list.
    function automatic logic [15:0] spec_outs(input int st, input bit mr, input bit r);
        if (r) return 16'h0000;
        case (st)
            0:       return mr ? 16'h9410 : 16'h1010;
            1:       return 16'h0030;
            2:       return 16'h0060;
            3:       return 16'h3000;
            4:       return 16'h0280;
            5:       return 16'h2800;
            6:       return 16'h0048;
            7:       return 16'h0180;
            8:       return 16'h4045;
            9:       return 16'h8002;
            10:      return 16'h0060;
            11:      return 16'h0080;
            default: return 16'h0000;
        endcase
    endfunction

    typedef struct {
        bit          rst;
        logic [5:0]  opc;
        bit          mr;
        int          st;
        logic [15:0] outs;
        int unsigned cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [5:0] o, input bit m, input int s,
                       input logic [15:0] ou, input int unsigned c);
        vec_t v;
        v.rst = r; v.opc = o; v.mr = m; v.st = s; v.outs = ou; v.cnt = c;
        tbl.push_back(v);
    endtask

    // Reference model: each instruction is a path of states; memory states wait.
    int          m_path[6];
    int          m_len;
    int          m_pos;
    bit          m_ill;
    int unsigned m_cnt;

    task automatic route(input logic [5:0] op);
        m_path[0] = 0; m_path[1] = 1;
        case (op)
            LW:      begin m_path[2] = 2; m_path[3] = 3; m_path[4] = 4; m_len = 5; end
            SW:      begin m_path[2] = 2; m_path[3] = 5; m_len = 4; end
            RT:      begin m_path[2] = 6; m_path[3] = 7; m_len = 4; end
            BEQ:     begin m_path[2] = 8; m_len = 3; end
            JMP:     begin m_path[2] = 9; m_len = 3; end
            ADDI:    begin m_path[2] = 10; m_path[3] = 11; m_len = 4; end
            default: begin m_path[2] = 12; m_len = 3; end
        endcase
    endtask

    function automatic int m_state();
        return m_path[m_pos];
    endfunction

    task automatic model_step(input bit r, input logic [5:0] op, input bit mr);
        int cur;
        if (r) begin
            m_pos = 0; m_path[0] = 0; m_ill = 1'b0; m_cnt = 0;
            return;
        end
        if (m_pos == 0) route(op);
        cur = m_path[m_pos];
        if (cur == 12) return;
        if ((cur == 0 || cur == 3 || cur == 5) && !mr) return;
        if (m_pos == m_len - 1) begin
            m_pos = 0;
            m_cnt++;
        end else begin
            m_pos++;
            if (m_path[m_pos] == 12) m_ill = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] rop;
        bit         rr, rmr;

        // Directed table: lw, sw with MEMWR stall, R/beq/j/addi, then reset.
        add(0, LW, 1, 0, 16'h9410, 0); add(0, LW, 1, 1, 16'h0030, 0);
        add(0, LW, 1, 2, 16'h0060, 0); add(0, LW, 1, 3, 16'h3000, 0);
        add(0, LW, 1, 4, 16'h0280, 0);
        add(0, SW, 1, 0, 16'h9410, 1); add(0, SW, 1, 1, 16'h0030, 1);
        add(0, SW, 1, 2, 16'h0060, 1); add(0, SW, 0, 5, 16'h2800, 1);
        add(0, SW, 0, 5, 16'h2800, 1); add(0, SW, 0, 5, 16'h2800, 1);
        add(0, SW, 1, 5, 16'h2800, 1);
        add(0, RT, 1, 0, 16'h9410, 2); add(0, RT, 1, 1, 16'h0030, 2);
        add(0, RT, 1, 6, 16'h0048, 2); add(0, RT, 1, 7, 16'h0180, 2);
        add(0, BEQ, 1, 0, 16'h9410, 3); add(0, BEQ, 1, 1, 16'h0030, 3);
        add(0, BEQ, 1, 8, 16'h4045, 3);
        add(0, JMP, 1, 0, 16'h9410, 4); add(0, JMP, 1, 1, 16'h0030, 4);
        add(0, JMP, 1, 9, 16'h8002, 4);
        add(0, ADDI, 1, 0, 16'h9410, 5); add(0, ADDI, 1, 1, 16'h0030, 5);
        add(0, ADDI, 1, 10, 16'h0060, 5); add(0, ADDI, 1, 11, 16'h0080, 5);
        add(0, RT, 0, 0, 16'h1010, 6);
        add(1, LW, 1, 0, 16'h0000, 6);
        add(0, RT, 0, 0, 16'h1010, 0);

        drive(1, RT, 1);
        chk("reset_outs", 32'(outs), 32'h0);
        tick();
        drive(1, RT, 0);
        tick();
        drive(0, RT, 0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_illegal", 32'(illegal_op), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].opc, tbl[i].mr);
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_outs", i), 32'(outs), 32'(tbl[i].outs));
            chk($sformatf("tbl%0d_count", i), instr_count, tbl[i].cnt);
            tick();
        end

        // FETCH stall continues, then completes into DECODE with an illegal opcode.
        drive(0, 6'h3f, 0);
        chk("fstall_state", 32'(state), 32'd0);
        chk("fstall_outs", 32'(outs), 32'h1010);
        tick();
        drive(0, 6'h3f, 1);
        chk("fdone_outs", 32'(outs), 32'h9410);
        tick();
        drive(0, 6'h3f, 1);
        chk("decode_state", 32'(state), 32'd1);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            chk("trap_state", 32'(state), 32'd12);
            chk("trap_illegal", 32'(illegal_op), 32'd1);
            chk("trap_outs", 32'(outs), 32'h0);
            tick();
        end
        drive(1, LW, 1);
        chk("trap_rst_outs", 32'(outs), 32'h0);
        tick();
        drive(0, LW, 1);
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_illegal", 32'(illegal_op), 32'd0);
        chk("trap_rst_count", instr_count, 32'd0);
        tick();

        // Reset in the middle of a MEMRD stall.
        drive(0, LW, 1); tick();
        drive(0, LW, 1); tick();
        drive(0, LW, 0);
        chk("memrd_state", 32'(state), 32'd3);
        tick();
        drive(1, LW, 1);
        chk("memrd_rst_outs", 32'(outs), 32'h0);
        tick();
        drive(0, LW, 0);
        chk("memrd_rst_state", 32'(state), 32'd0);
        chk("memrd_rst_outs2", 32'(outs), 32'h1010);
        tick();

        // Randomized run against the path model.
        drive(1, RT, 1);
        model_step(1, RT, 1);
        tick();
        rop = RT;
        for (int c = 0; c < 3000; c++) begin
            rr  = ($urandom_range(0, 99) == 0);
            rmr = ($urandom_range(0, 3) != 0);
            if (m_state() == 0) begin
                case ($urandom_range(0, 12))
                    0, 1:    rop = LW;
                    2, 3:    rop = SW;
                    4, 5:    rop = RT;
                    6, 7:    rop = BEQ;
                    8, 9:    rop = JMP;
                    10, 11:  rop = ADDI;
                    default: rop = 6'($urandom_range(0, 63));
                endcase
            end
            drive(rr, rop, rmr);
            chk("rnd_state", 32'(state), 32'(m_state()));
            chk("rnd_outs", 32'(outs), 32'(spec_outs(m_state(), rmr, rr)));
            chk("rnd_illegal", 32'(illegal_op), 32'(m_ill));
            chk("rnd_count", instr_count, m_cnt);
            model_step(rr, rop, rmr);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
